// File: rtl/usb_phy_pkg.sv
// Shared UTMI/USB constants for the device reset responder and the host reset controller.
// Line-state, op_mode, transceiver/termination, speed codes and the device reset FSM states.
package usb_phy_pkg;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [1:0] SPD_UNKNOWN = 2'b00;
  localparam logic [1:0] SPD_FULL    = 2'b01;
  localparam logic [1:0] SPD_HIGH    = 2'b10;

  localparam logic [1:0] OP_NORMAL = 2'b00;
  localparam logic [1:0] OP_CHIRP  = 2'b10;

  localparam logic [1:0] XCVR_HS = 2'b00;
  localparam logic [1:0] XCVR_FS = 2'b01;

  localparam logic TERM_HS = 1'b0;
  localparam logic TERM_FS = 1'b1;

  // Chirp K is sent as all-zero data with bit stuffing and NRZI disabled.
  localparam logic [7:0] CHIRP_DATA = 8'h00;

  typedef enum logic [2:0] {
    ST_FS_IDLE,
    ST_DEV_CHIRP,
    ST_WAIT_HOST_K,
    ST_HOST_K,
    ST_HOST_J,
    ST_HS_IDLE,
    ST_HS_REVERT,
    ST_WAIT_RESET_END
  } dev_state_e;

  function automatic logic is_host_chirp(input dev_state_e s);
    return (s == ST_WAIT_HOST_K) || (s == ST_HOST_K) || (s == ST_HOST_J);
  endfunction

endpackage

// File: rtl/usb_linestate_filter.sv
// Stable-run counter on UTMI line_state: strobes qual_k/qual_j/qual_se0 once when
// the same value has been sampled N consecutive cycles. clr restarts the run.
module usb_linestate_filter
  import usb_phy_pkg::*;
#(
  parameter int unsigned N = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [1:0] line_state,
  output logic       qual_k,
  output logic       qual_j,
  output logic       qual_se0
);

  localparam logic [31:0] N_C = 32'(N);

  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  prev_q, prev_d;
  logic        same, hit;

  always_comb begin
    same   = (line_state == prev_q);
    prev_d = line_state;
    if (clr)              cnt_d = '0;
    else if (!same)       cnt_d = 32'd1;
    else if (cnt_q == N_C) cnt_d = cnt_q;
    else                  cnt_d = cnt_q + 32'd1;
    // Saturated runs must not re-strobe every cycle.
    hit      = !clr && (cnt_d == N_C) && !(same && (cnt_q == N_C));
    qual_k   = hit && (line_state == LS_K);
    qual_j   = hit && (line_state == LS_J);
    qual_se0 = hit && (line_state == LS_SE0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prev_q <= LS_J;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/usb_device_reset_responder.sv
// Device-side USB bus reset detector and HS chirp handshake responder on a UTMI PHY.
// Owns op_mode/xcvr_select/term_select; reports the negotiated speed to the link layer.
module usb_device_reset_responder
  import usb_phy_pkg::*;
#(
  parameter int unsigned RESET_DETECT_CYCLES   = 150,
  parameter int unsigned HS_IDLE_REVERT_CYCLES = 180000,
  parameter int unsigned REVERT_SAMPLE_CYCLES  = 100,
  parameter int unsigned DEV_CHIRP_CYCLES      = 120000,
  parameter int unsigned HOST_CHIRP_MIN_CYCLES = 150,
  parameter int unsigned CHIRP_PAIRS           = 3,
  parameter int unsigned HS_DETECT_TIMEOUT     = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hs_capable,
  input  logic [1:0] phy_line_state,
  input  logic       utmi_tx_ready,
  output logic       bus_reset,
  output logic       reset_active,
  output logic       suspend_detect,
  output logic [1:0] detected_speed,
  output logic [1:0] phy_op_mode,
  output logic [1:0] phy_xcvr_select,
  output logic       phy_term_select,
  output logic [7:0] utmi_tx_data,
  output logic       utmi_tx_valid
);

  localparam logic [31:0] REVERT_C  = 32'(HS_IDLE_REVERT_CYCLES);
  localparam logic [31:0] SAMPLE_C  = 32'(REVERT_SAMPLE_CYCLES);
  localparam logic [31:0] DEVCHIRP_C = 32'(DEV_CHIRP_CYCLES);
  localparam logic [31:0] TIMEOUT_C = 32'(HS_DETECT_TIMEOUT);
  localparam logic [7:0]  PAIRS_C   = 8'(CHIRP_PAIRS);

  dev_state_e  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  pair_q, pair_d;
  logic        started_q, started_d;
  logic [1:0]  speed_q, speed_d;
  logic        rst_act_q, rst_act_d;
  logic        bus_rst_q, bus_rst_d;
  logic        susp_q, susp_d;

  logic       se0_qual, chirp_k, chirp_j;
  logic [2:0] unused_filt;

  usb_linestate_filter #(.N(RESET_DETECT_CYCLES)) u_rst_filt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state_q != ST_FS_IDLE),
    .line_state (phy_line_state),
    .qual_k     (unused_filt[0]),
    .qual_j     (unused_filt[1]),
    .qual_se0   (se0_qual)
  );

  usb_linestate_filter #(.N(HOST_CHIRP_MIN_CYCLES)) u_chirp_filt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (!is_host_chirp(state_q)),
    .line_state (phy_line_state),
    .qual_k     (chirp_k),
    .qual_j     (chirp_j),
    .qual_se0   (unused_filt[2])
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 32'd1;
    pair_d    = pair_q;
    started_d = started_q;
    speed_d   = speed_q;
    rst_act_d = rst_act_q;
    bus_rst_d = 1'b0;
    susp_d    = 1'b0;

    case (state_q)
      ST_FS_IDLE: begin
        if (se0_qual) begin
          bus_rst_d = 1'b1;
          rst_act_d = 1'b1;
          state_d   = hs_capable ? ST_DEV_CHIRP : ST_WAIT_RESET_END;
        end
      end
      ST_DEV_CHIRP: begin
        // Chirp duration is measured from the first cycle the PHY takes data.
        started_d = started_q | utmi_tx_ready;
        timer_d   = started_d ? timer_q + 32'd1 : '0;
        if (timer_d == DEVCHIRP_C) state_d = ST_WAIT_HOST_K;
      end
      ST_WAIT_HOST_K, ST_HOST_K, ST_HOST_J: begin
        if (chirp_k) begin
          state_d = ST_HOST_K;
        end else if (chirp_j && (state_q == ST_HOST_K)) begin
          pair_d  = pair_q + 8'd1;
          state_d = (pair_d == PAIRS_C) ? ST_HS_IDLE : ST_HOST_J;
        end
        if ((state_d != ST_HS_IDLE) && (timer_d == TIMEOUT_C)) state_d = ST_WAIT_RESET_END;
        if (state_d == ST_HS_IDLE) begin
          speed_d   = SPD_HIGH;
          rst_act_d = 1'b0;
        end
      end
      ST_HS_IDLE: begin
        timer_d = (phy_line_state == LS_SE0) ? timer_q + 32'd1 : '0;
        if (timer_d == REVERT_C) state_d = ST_HS_REVERT;
      end
      ST_HS_REVERT: begin
        if (timer_d >= SAMPLE_C) begin
          if (phy_line_state == LS_SE0) begin
            bus_rst_d = 1'b1;
            rst_act_d = 1'b1;
            state_d   = hs_capable ? ST_DEV_CHIRP : ST_WAIT_RESET_END;
          end else if (phy_line_state == LS_J) begin
            susp_d  = 1'b1;
            state_d = ST_FS_IDLE;
          end
        end
      end
      ST_WAIT_RESET_END: begin
        if (phy_line_state == LS_J) begin
          speed_d   = SPD_FULL;
          rst_act_d = 1'b0;
          state_d   = ST_FS_IDLE;
        end
      end
      default: state_d = ST_FS_IDLE;
    endcase

    // The HS detect timeout spans all three host-chirp states.
    if ((state_d != state_q) && !(is_host_chirp(state_q) && is_host_chirp(state_d)))
      timer_d = '0;
    if ((state_d == ST_DEV_CHIRP) && (state_q != ST_DEV_CHIRP)) begin
      pair_d    = '0;
      started_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FS_IDLE;
      timer_q   <= '0;
      pair_q    <= '0;
      started_q <= 1'b0;
      speed_q   <= SPD_UNKNOWN;
      rst_act_q <= 1'b0;
      bus_rst_q <= 1'b0;
      susp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pair_q    <= pair_d;
      started_q <= started_d;
      speed_q   <= speed_d;
      rst_act_q <= rst_act_d;
      bus_rst_q <= bus_rst_d;
      susp_q    <= susp_d;
    end
  end

  always_comb begin
    phy_op_mode     = OP_NORMAL;
    phy_xcvr_select = XCVR_FS;
    phy_term_select = TERM_FS;
    utmi_tx_valid   = 1'b0;
    case (state_q)
      ST_DEV_CHIRP: begin
        phy_op_mode     = OP_CHIRP;
        phy_xcvr_select = XCVR_HS;
        utmi_tx_valid   = 1'b1;
      end
      ST_WAIT_HOST_K, ST_HOST_K, ST_HOST_J: begin
        phy_op_mode     = OP_CHIRP;
        phy_xcvr_select = XCVR_HS;
      end
      ST_HS_IDLE: begin
        phy_xcvr_select = XCVR_HS;
        phy_term_select = TERM_HS;
      end
      default: ;
    endcase
  end

  assign utmi_tx_data   = CHIRP_DATA;
  assign bus_reset      = bus_rst_q;
  assign reset_active   = rst_act_q;
  assign suspend_detect = susp_q;
  assign detected_speed = speed_q;

endmodule

// File: tb/tb_usb_device_reset_responder.sv
// Directed bench for usb_device_reset_responder with shortened timing parameters.
// Expected values are hand-derived cycle counts from the parameter set below.
module tb_usb_device_reset_responder;
  import usb_phy_pkg::*;

  localparam int RST_DET = 150;
  localparam int REVERT  = 400;
  localparam int SAMPLE  = 10;
  localparam int DEVC    = 300;
  localparam int HMIN    = 20;
  localparam int PAIRS   = 3;
  localparam int TMO     = 500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs_capable = 1'b1;
  logic [1:0] ls = LS_J;
  logic       utmi_tx_ready = 1'b0;
  logic       bus_reset, reset_active, suspend_detect, phy_term_select, utmi_tx_valid;
  logic [1:0] detected_speed, phy_op_mode, phy_xcvr_select;
  logic [7:0] utmi_tx_data;

  int n_chk = 0, n_pass = 0, n_rst = 0, n_susp = 0;

  always #5 clk = ~clk;

  usb_device_reset_responder #(
    .RESET_DETECT_CYCLES(RST_DET), .HS_IDLE_REVERT_CYCLES(REVERT),
    .REVERT_SAMPLE_CYCLES(SAMPLE), .DEV_CHIRP_CYCLES(DEVC),
    .HOST_CHIRP_MIN_CYCLES(HMIN), .CHIRP_PAIRS(PAIRS), .HS_DETECT_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hs_capable(hs_capable), .phy_line_state(ls),
    .utmi_tx_ready(utmi_tx_ready), .bus_reset(bus_reset), .reset_active(reset_active),
    .suspend_detect(suspend_detect), .detected_speed(detected_speed),
    .phy_op_mode(phy_op_mode), .phy_xcvr_select(phy_xcvr_select),
    .phy_term_select(phy_term_select), .utmi_tx_data(utmi_tx_data),
    .utmi_tx_valid(utmi_tx_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus_reset) n_rst++;
      if (suspend_detect) n_susp++;
    end
  endtask

  task automatic chk_fs_out(input string tag);
    chk({tag, "_op"}, 32'(phy_op_mode), 32'(OP_NORMAL));
    chk({tag, "_xcvr"}, 32'(phy_xcvr_select), 32'(XCVR_FS));
    chk({tag, "_term"}, 32'(phy_term_select), 32'(TERM_FS));
    chk({tag, "_txv"}, 32'(utmi_tx_valid), 32'd0);
  endtask

  // SE0 reset, full device chirp (tx_ready already high), then PAIRS host K-J pairs.
  task automatic hs_handshake(input string tag);
    int base;
    base = n_rst;
    ls = LS_SE0; tick(RST_DET);
    chk({tag, "_busrst"}, 32'(n_rst - base), 32'd1);
    tick(DEVC);
    chk({tag, "_chirp_end"}, 32'(utmi_tx_valid), 32'd0);
    for (int p = 0; p < PAIRS; p++) begin
      ls = LS_K; tick(30);
      ls = LS_J;
      if (p == PAIRS - 1) begin
        tick(HMIN - 1);
        chk({tag, "_term_pre"}, 32'(phy_term_select), 32'(TERM_FS));
        tick(1);
      end else tick(30);
    end
    chk({tag, "_term_hs"}, 32'(phy_term_select), 32'(TERM_HS));
    chk({tag, "_xcvr_hs"}, 32'(phy_xcvr_select), 32'(XCVR_HS));
    chk({tag, "_op_hs"}, 32'(phy_op_mode), 32'(OP_NORMAL));
    chk({tag, "_spd_hs"}, 32'(detected_speed), 32'(SPD_HIGH));
    chk({tag, "_ract_hs"}, 32'(reset_active), 32'd0);
  endtask

  initial begin
    int base, cnt;
    // Reset state
    #1;
    chk_fs_out("rst");
    chk("rst_spd", 32'(detected_speed), 32'(SPD_UNKNOWN));
    chk("rst_pulses", 32'({bus_reset, reset_active, suspend_detect}), 32'd0);
    chk("rst_txd", 32'(utmi_tx_data), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Glitch: 149 cycles of SE0 must not declare reset
    ls = LS_SE0; tick(149);
    ls = LS_J; tick(5);
    chk("glitch_busrst", 32'(n_rst), 32'd0);
    chk("glitch_ract", 32'(reset_active), 32'd0);
    chk_fs_out("glitch");

    // FS host: reset at SE0 cycle 150, chirp held until ready, no host chirps
    ls = LS_SE0; tick(149);
    chk("fs_busrst_149", 32'(n_rst), 32'd0);
    tick(1);
    chk("fs_busrst_150", 32'(bus_reset), 32'd1);
    chk("fs_ract", 32'(reset_active), 32'd1);
    chk("fs_txv", 32'(utmi_tx_valid), 32'd1);
    chk("fs_op_chirp", 32'(phy_op_mode), 32'(OP_CHIRP));
    tick(1);
    chk("fs_busrst_pulse", 32'(bus_reset), 32'd0);
    tick(49);
    chk("fs_txv_hold", 32'(utmi_tx_valid), 32'd1);
    utmi_tx_ready = 1'b1;
    cnt = 1;
    for (int i = 0; i < DEVC + 20; i++) begin
      tick(1);
      if (utmi_tx_valid) cnt++;
      else break;
    end
    chk("fs_chirp_len", 32'(cnt), 32'(DEVC));
    chk("fs_wait_op", 32'(phy_op_mode), 32'(OP_CHIRP));
    tick(TMO - 1);
    chk("fs_pre_tmo_op", 32'(phy_op_mode), 32'(OP_CHIRP));
    tick(1);
    chk_fs_out("fs_tmo");
    chk("fs_tmo_ract", 32'(reset_active), 32'd1);
    ls = LS_J; tick(1);
    chk("fs_spd", 32'(detected_speed), 32'(SPD_FULL));
    chk("fs_ract_end", 32'(reset_active), 32'd0);
    chk("fs_term", 32'(phy_term_select), 32'(TERM_FS));

    // HS host
    hs_handshake("hs1");

    // HS suspend: SE0 revert then J
    ls = LS_SE0; tick(REVERT - 1);
    chk("susp_pre_xcvr", 32'(phy_xcvr_select), 32'(XCVR_HS));
    tick(1);
    chk("susp_revert_xcvr", 32'(phy_xcvr_select), 32'(XCVR_FS));
    chk("susp_revert_term", 32'(phy_term_select), 32'(TERM_FS));
    ls = LS_J; tick(SAMPLE - 1);
    chk("susp_early", 32'(n_susp), 32'd0);
    tick(1);
    chk("susp_pulse", 32'(suspend_detect), 32'd1);
    chk("susp_spd", 32'(detected_speed), 32'(SPD_HIGH));
    chk("susp_ract", 32'(reset_active), 32'd0);
    tick(1);
    chk("susp_once", 32'(n_susp), 32'd1);

    // HS reset: SE0 held through the revert sample
    hs_handshake("hs2");
    base = n_rst;
    ls = LS_SE0; tick(REVERT + SAMPLE - 1);
    chk("hsrst_early", 32'(n_rst - base), 32'd0);
    tick(1);
    chk("hsrst_pulse", 32'(bus_reset), 32'd1);
    chk("hsrst_txv", 32'(utmi_tx_valid), 32'd1);
    chk("hsrst_ract", 32'(reset_active), 32'd1);

    // Chirp noise: short K ignored, only 2 pairs -> FS fallback at timeout
    tick(DEVC);
    ls = LS_K; tick(30); ls = LS_J; tick(30);
    ls = LS_K; tick(10); ls = LS_J; tick(30);
    ls = LS_K; tick(30); ls = LS_J; tick(30);
    tick(TMO - 160 - 1);
    chk("noise_op", 32'(phy_op_mode), 32'(OP_CHIRP));
    chk("noise_term", 32'(phy_term_select), 32'(TERM_FS));
    tick(1);
    chk_fs_out("noise_tmo");
    tick(1);
    chk("noise_spd", 32'(detected_speed), 32'(SPD_FULL));

    // Async reset during HOST_J
    ls = LS_SE0; tick(RST_DET + DEVC);
    ls = LS_K; tick(30); ls = LS_J; tick(30);
    chk("hj_op", 32'(phy_op_mode), 32'(OP_CHIRP));
    #2 rst_n = 1'b0;
    #1;
    chk_fs_out("arst");
    chk("arst_spd", 32'(detected_speed), 32'(SPD_UNKNOWN));
    tick(1);
    chk("arst_xcvr_clk", 32'(phy_xcvr_select), 32'(XCVR_FS));
    rst_n = 1'b1;
    ls = LS_J; tick(2);

    // Non-HS-capable device: straight to FS
    hs_capable = 1'b0;
    ls = LS_SE0; tick(RST_DET);
    chk("nohs_busrst", 32'(bus_reset), 32'd1);
    chk_fs_out("nohs");
    chk("nohs_ract", 32'(reset_active), 32'd1);
    ls = LS_J; tick(1);
    chk("nohs_spd", 32'(detected_speed), 32'(SPD_FULL));
    chk("nohs_ract_end", 32'(reset_active), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
